l2_trace_dispatcher: RTL and testbench
======================================

Name: l2_trace_dispatcher

Overview:
Upstream feeder for the L2 cache controller. Accepts trace commands (opcode plus 32-bit address) from the trace reader and buffers them in a small FIFO. Issues cache opcodes 0-6 to the controller one at a time, with the address already split into tag, index and offset. Handles control opcodes 8 (clear) and 9 (print) locally and keeps the processor-reference statistics.

Parameters:
DEPTH, 8, FIFO entries (power of 2, at least 2)
CNT_W, 32, width of each statistics counter
TAG_BITS, 12, tag width (taken from cache_config_pkg)
INDEX_BITS, 14, set index width (taken from cache_config_pkg)
OFFSET_BITS, 6, block offset width (taken from cache_config_pkg)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
in_valid  in  1  trace command valid
in_ready  out  1  FIFO can accept; equals not-full
in_op  in  4  trace opcode 0-15
in_addr  in  32  trace address
req_valid  out  1  request to cache controller
req_ready  in  1  cache controller accepts request
req_op  out  3  cache opcode 0-6
req_addr  out  32  full address
req_tag  out  TAG_BITS  req_addr[31:20]
req_index  out  INDEX_BITS  req_addr[19:6]
req_offset  out  OFFSET_BITS  req_addr[5:0]
rsp_valid  in  1  cache controller finished current request
rsp_hit  in  1  1 = hit, 0 = miss; qualified by rsp_valid
clear_pulse  out  1  one-cycle pulse: invalidate all sets and PLRU
print_pulse  out  1  one-cycle pulse: dump cache contents
bad_op  out  1  one-cycle pulse: illegal opcode dropped
busy  out  1  FIFO non-empty or FSM not in IDLE
cnt_reads  out  CNT_W  opcode 0 and 2 completions
cnt_writes  out  CNT_W  opcode 1 completions
cnt_hits  out  CNT_W  hits on opcodes 0-2
cnt_misses  out  CNT_W  misses on opcodes 0-2

Behaviour:
- Reset: FIFO emptied; FSM to IDLE; all outputs 0 except in_ready = 1; all counters 0. Reset in any state aborts the in-flight request and no counter is updated for it.
- FIFO push happens when in_valid && in_ready. When full, in_ready = 0 even in a cycle that pops.
- A pushed entry is visible to the FSM on the next cycle. The FIFO head is popped only in IDLE.
- Opcodes 7 and 10-15 are dropped when popped: bad_op pulses for 1 cycle, FSM stays in IDLE.
- FSM states: IDLE, ISSUE, WAIT_RSP, CLEAR, PRINT.
- IDLE, FIFO non-empty: pop the head.
  - Opcode 0-6: latch op/addr into the request register, go to ISSUE.
  - Opcode 8: go to CLEAR.
  - Opcode 9: go to PRINT.
- ISSUE: req_valid = 1. req_* outputs are registered and held stable until req_valid && req_ready, then go to WAIT_RSP. req_valid drops the cycle after the handshake.
- WAIT_RSP: wait for rsp_valid.
  - Opcodes 0-2 only: increment the read or write counter, plus cnt_hits if rsp_hit else cnt_misses.
  - Snoop opcodes 3-6 leave all counters unchanged.
  - Return to IDLE.
  - rsp_valid in any other state is ignored.
- CLEAR: clear_pulse = 1 for exactly 1 cycle, all four counters zeroed that cycle, back to IDLE.
- PRINT: print_pulse = 1 for exactly 1 cycle, counters unchanged, back to IDLE.
- Throughput: at most one outstanding request.
  - Minimum request issue is 2 cycles after push (pop cycle, then ISSUE).
  - Minimum per-request occupancy is 3 cycles (IDLE, ISSUE, WAIT_RSP).
- Counters saturate at all-ones and never wrap.
- Address split is a pure bit slice of the latched address. No arithmetic is performed on the address.

Decomposition:
- Add to cache_config_pkg:
  - trace_op_e: RD_L1D = 0, WR_L1D = 1, RD_L1I = 2, SNP_RD = 3, SNP_WR = 4, SNP_RWIM = 5, SNP_INV = 6, CLR = 8, PRT = 9.
  - disp_state_e for the FSM states.
  - The existing TAG_BITS, INDEX_BITS and BLOCK_OFFSET_BITS constants.
- One sub-module: trace_fifo, a parameterised synchronous FIFO with DEPTH, data width 36, push/pop, full/empty. The dispatcher FSM and counters stay in the top module.

Test Plan:
- Split and timing: push op 0, addr 0x12345678 in cycle 0, req_ready tied 1.
  - req_valid is high in cycle 2 only.
  - req_tag = 0x123, req_index = 0x1159, req_offset = 0x38.
  - rsp_valid with hit = 1 in cycle 3 gives cnt_reads = 1 and cnt_hits = 1.
- Backpressure: req_ready = 0 for 5 cycles. req_valid and req_* stay stable throughout; handshake occurs on the first req_ready = 1; exactly one request is issued.
- FIFO full: push 10 commands back-to-back with req_ready = 0.
  - in_ready goes low after 8 accepted; entries 9 and 10 are not accepted.
  - Release req_ready and answer every request with rsp_valid: the 8 accepted entries issue in order.
- Counter mix: ops 1 (miss), 2 (hit), 3 (hit), 5 (miss), each answered with rsp_valid. Result: reads = 1, writes = 1, hits = 1, misses = 1.
- Control ops: with counters at reads = 3, issue op 9 then op 8.
  - print_pulse lasts 1 cycle and counters are unchanged.
  - clear_pulse lasts 1 cycle and all counters become 0.
  - op 7 yields bad_op = 1 with no req_valid.
- Reset mid-flight: assert rst while in WAIT_RSP with 3 entries queued. Next cycle busy = 0, in_ready = 1, counters 0, and no req_valid follows.

Source files
------------

// File: rtl/cache_config_pkg.sv
// Shared L2 cache geometry, trace opcodes and dispatcher types.
// Address layout: tag [31:20], set index [19:6], block offset [5:0].
package cache_config_pkg;

    localparam int TAG_BITS          = 12;
    localparam int INDEX_BITS        = 14;
    localparam int BLOCK_OFFSET_BITS = 6;
    localparam int ADDR_BITS         = TAG_BITS + INDEX_BITS + BLOCK_OFFSET_BITS;

    typedef enum logic [3:0] {
        RD_L1D   = 4'd0,
        WR_L1D   = 4'd1,
        RD_L1I   = 4'd2,
        SNP_RD   = 4'd3,
        SNP_WR   = 4'd4,
        SNP_RWIM = 4'd5,
        SNP_INV  = 4'd6,
        CLR      = 4'd8,
        PRT      = 4'd9
    } trace_op_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ISSUE    = 3'd1,
        ST_WAIT_RSP = 3'd2,
        ST_CLEAR    = 3'd3,
        ST_PRINT    = 3'd4
    } disp_state_e;

    typedef struct packed {
        logic [3:0]           op;
        logic [ADDR_BITS-1:0] addr;
    } trace_cmd_t;

    localparam int CMD_W = $bits(trace_cmd_t);

endpackage

// File: rtl/l2_trace_dispatcher_if.sv
// Trace-in, cache-request and cache-response signals of the dispatcher.
// slave = dispatcher side, master = reader/controller side.
interface l2_trace_dispatcher_if;
    import cache_config_pkg::*;

    logic                         in_valid;
    logic                         in_ready;
    logic [3:0]                   in_op;
    logic [ADDR_BITS-1:0]         in_addr;

    logic                         req_valid;
    logic                         req_ready;
    logic [2:0]                   req_op;
    logic [ADDR_BITS-1:0]         req_addr;
    logic [TAG_BITS-1:0]          req_tag;
    logic [INDEX_BITS-1:0]        req_index;
    logic [BLOCK_OFFSET_BITS-1:0] req_offset;

    logic                         rsp_valid;
    logic                         rsp_hit;

    modport slave (
        input  in_valid, in_op, in_addr,
        output in_ready,
        output req_valid, req_op, req_addr,
        output req_tag, req_index, req_offset,
        input  req_ready,
        input  rsp_valid, rsp_hit
    );

    modport master (
        output in_valid, in_op, in_addr,
        input  in_ready,
        input  req_valid, req_op, req_addr,
        input  req_tag, req_index, req_offset,
        output req_ready,
        output rsp_valid, rsp_hit
    );

endinterface

// File: rtl/trace_fifo.sv
// Synchronous FIFO holding trace commands between the reader and dispatcher.
// Head entry is presented combinationally on rdata whenever not empty.
module trace_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 36
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/l2_trace_dispatcher.sv
// Feeds trace commands to the L2 controller one at a time, executes
// clear/print locally and keeps saturating processor-reference statistics.
module l2_trace_dispatcher
    import cache_config_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    l2_trace_dispatcher_if.slave   io,
    output logic                   clear_pulse,
    output logic                   print_pulse,
    output logic                   bad_op,
    output logic                   busy,
    output logic [CNT_W-1:0]       cnt_reads,
    output logic [CNT_W-1:0]       cnt_writes,
    output logic [CNT_W-1:0]       cnt_hits,
    output logic [CNT_W-1:0]       cnt_misses
);

    disp_state_e          state_q, state_d;
    logic [2:0]           req_op_q, req_op_d;
    logic [ADDR_BITS-1:0] req_addr_q, req_addr_d;
    logic                 bad_op_q, bad_op_d;
    logic [CNT_W-1:0]     rd_q, rd_d;
    logic [CNT_W-1:0]     wr_q, wr_d;
    logic [CNT_W-1:0]     hit_q, hit_d;
    logic [CNT_W-1:0]     miss_q, miss_d;

    logic                 fifo_full, fifo_empty, pop;
    trace_cmd_t           in_cmd, head;
    logic                 is_cache, is_clr, is_prt;

    assign in_cmd = '{op: io.in_op, addr: io.in_addr};

    trace_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (io.in_valid && !fifo_full),
        .pop   (pop),
        .wdata (in_cmd),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign is_cache = (head.op <= SNP_INV);
    assign is_clr   = (head.op == CLR);
    assign is_prt   = (head.op == PRT);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_comb begin
        state_d    = state_q;
        req_op_d   = req_op_q;
        req_addr_d = req_addr_q;
        bad_op_d   = 1'b0;
        rd_d       = rd_q;
        wr_d       = wr_q;
        hit_d      = hit_q;
        miss_d     = miss_q;
        pop        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                    unique case (1'b1)
                        is_cache: begin
                            req_op_d   = head.op[2:0];
                            req_addr_d = head.addr;
                            state_d    = ST_ISSUE;
                        end
                        is_clr:  state_d  = ST_CLEAR;
                        is_prt:  state_d  = ST_PRINT;
                        default: bad_op_d = 1'b1;
                    endcase
                end
            end
            ST_ISSUE: begin
                if (io.req_ready) state_d = ST_WAIT_RSP;
            end
            ST_WAIT_RSP: begin
                if (io.rsp_valid) begin
                    // Only processor-side references are counted; snoops are not.
                    if (req_op_q <= 3'(RD_L1I)) begin
                        if (req_op_q == 3'(WR_L1D)) wr_d = sat_inc(wr_q);
                        else                        rd_d = sat_inc(rd_q);
                        if (io.rsp_hit) hit_d  = sat_inc(hit_q);
                        else            miss_d = sat_inc(miss_q);
                    end
                    state_d = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                rd_d    = '0;
                wr_d    = '0;
                hit_d   = '0;
                miss_d  = '0;
                state_d = ST_IDLE;
            end
            ST_PRINT: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            req_op_q   <= '0;
            req_addr_q <= '0;
            bad_op_q   <= 1'b0;
            rd_q       <= '0;
            wr_q       <= '0;
            hit_q      <= '0;
            miss_q     <= '0;
        end else begin
            state_q    <= state_d;
            req_op_q   <= req_op_d;
            req_addr_q <= req_addr_d;
            bad_op_q   <= bad_op_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            hit_q      <= hit_d;
            miss_q     <= miss_d;
        end
    end

    assign io.in_ready   = !fifo_full;
    assign io.req_valid  = (state_q == ST_ISSUE);
    assign io.req_op     = req_op_q;
    assign io.req_addr   = req_addr_q;
    assign io.req_tag    = req_addr_q[ADDR_BITS-1 -: TAG_BITS];
    assign io.req_index  = req_addr_q[BLOCK_OFFSET_BITS +: INDEX_BITS];
    assign io.req_offset = req_addr_q[BLOCK_OFFSET_BITS-1:0];

    assign clear_pulse = (state_q == ST_CLEAR);
    assign print_pulse = (state_q == ST_PRINT);
    assign bad_op      = bad_op_q;
    assign busy        = !fifo_empty || (state_q != ST_IDLE);

    assign cnt_reads  = rd_q;
    assign cnt_writes = wr_q;
    assign cnt_hits   = hit_q;
    assign cnt_misses = miss_q;

endmodule

// File: tb/tb_l2_trace_dispatcher.sv
// Directed and randomized checks of l2_trace_dispatcher against a
// queue-based command/statistics model.
module tb_l2_trace_dispatcher;
    import cache_config_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    l2_trace_dispatcher_if bus ();

    logic        clear_pulse, print_pulse, bad_op, busy;
    logic [31:0] cnt_reads, cnt_writes, cnt_hits, cnt_misses;

    l2_trace_dispatcher #(.DEPTH(8), .CNT_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .io          (bus),
        .clear_pulse (clear_pulse),
        .print_pulse (print_pulse),
        .bad_op      (bad_op),
        .busy        (busy),
        .cnt_reads   (cnt_reads),
        .cnt_writes  (cnt_writes),
        .cnt_hits    (cnt_hits),
        .cnt_misses  (cnt_misses)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] addr;
    } cmd_t;

    int   n_pass  = 0;
    int   n_total = 0;
    cmd_t expq[$];
    bit   hitq[$];
    int   m_rd, m_wr, m_hit, m_miss;
    bit   outstanding;
    logic [2:0] out_op;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic chk_cnt(string tag);
        chk({tag, "_reads"},  cnt_reads,  m_rd);
        chk({tag, "_writes"}, cnt_writes, m_wr);
        chk({tag, "_hits"},   cnt_hits,   m_hit);
        chk({tag, "_misses"}, cnt_misses, m_miss);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Statistics rule: demand ops 0..2 count, op 1 is a write, snoops ignored.
    task automatic model_rsp(logic [2:0] op, bit hit);
        if (op <= 3'd2) begin
            if (op == 3'd1) m_wr++;
            else            m_rd++;
            if (hit) m_hit++;
            else     m_miss++;
        end
    endtask

    task automatic model_clear();
        m_rd = 0; m_wr = 0; m_hit = 0; m_miss = 0;
    endtask

    // One clock of reader + controller behaviour; ready_mode 0=low 1=high 2=random.
    task automatic svc(int ready_mode, bit do_push, logic [3:0] op,
                       logic [31:0] addr, output bit accepted);
        bit   h;
        cmd_t c;
        bus.rsp_valid = 1'b0;
        bus.rsp_hit   = 1'b0;
        if (outstanding && (ready_mode != 2 || $urandom_range(0, 2) != 0)) begin
            h = (hitq.size() != 0) ? hitq.pop_front() : 1'($urandom_range(0, 1));
            bus.rsp_valid = 1'b1;
            bus.rsp_hit   = h;
            model_rsp(out_op, h);
            outstanding = 1'b0;
        end
        bus.req_ready = (ready_mode == 1) ? 1'b1 :
                        (ready_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
        if (bus.req_valid && bus.req_ready) begin
            if (expq.size() == 0) begin
                chk("unexpected_req", bus.req_valid, 0);
            end else begin
                c = expq.pop_front();
                chk("req_op",     bus.req_op,     c.op);
                chk("req_addr",   bus.req_addr,   c.addr);
                chk("req_tag",    bus.req_tag,    c.addr / (2**20));
                chk("req_index",  bus.req_index,  (c.addr / 64) % (2**14));
                chk("req_offset", bus.req_offset, c.addr % 64);
                outstanding = 1'b1;
                out_op      = c.op;
            end
        end
        accepted = 1'b0;
        if (do_push) begin
            bus.in_valid = 1'b1;
            bus.in_op    = op;
            bus.in_addr  = addr;
            accepted     = bus.in_ready;
            if (accepted && op <= 4'd6) expq.push_back('{op[2:0], addr});
        end else begin
            bus.in_valid = 1'b0;
        end
        tick();
    endtask

    task automatic drain(int budget);
        bit acc;
        for (int i = 0; i < budget; i++) begin
            if (expq.size() == 0 && !outstanding && !busy) break;
            svc(1, 1'b0, 4'd0, 32'd0, acc);
        end
        chk("drain_queue_empty", 64'(expq.size()), 0);
        chk("drain_idle", busy, 0);
    endtask

    task automatic watch(int n, output int nc, output int np,
                         output int nb, output int nr);
        nc = 0; np = 0; nb = 0; nr = 0;
        bus.in_valid  = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.req_ready = 1'b0;
        for (int i = 0; i < n; i++) begin
            nc += int'(clear_pulse);
            np += int'(print_pulse);
            nb += int'(bad_op);
            nr += int'(bus.req_valid);
            tick();
        end
    endtask

    initial begin
        bit          acc;
        bit          accv[10];
        int          n_acc;
        int          nc, np, nb, nr;
        logic [31:0] bp_addr;

        bus.in_valid = 0; bus.in_op = 0; bus.in_addr = 0;
        bus.req_ready = 0; bus.rsp_valid = 0; bus.rsp_hit = 0;
        outstanding = 0; out_op = 0;
        model_clear();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_req_valid", bus.req_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pulses", {clear_pulse, print_pulse, bad_op}, 0);
        chk_cnt("rst");

        // Split and timing: push in cycle 0, request in cycle 2 only
        bus.req_ready = 1'b1;
        bus.in_valid = 1'b1; bus.in_op = 4'd0; bus.in_addr = 32'h1234_5678;
        tick();
        bus.in_valid = 1'b0;
        chk("t_c1_req_valid", bus.req_valid, 0);
        tick();
        chk("t_c2_req_valid", bus.req_valid, 1);
        chk("t_c2_tag", bus.req_tag, 12'h123);
        chk("t_c2_index", bus.req_index, 14'h1159);
        chk("t_c2_offset", bus.req_offset, 6'h38);
        chk("t_c2_op", bus.req_op, 0);
        tick();
        chk("t_c3_req_valid", bus.req_valid, 0);
        bus.rsp_valid = 1'b1; bus.rsp_hit = 1'b1;
        model_rsp(3'd0, 1'b1);
        tick();
        bus.rsp_valid = 1'b0;
        chk("t_reads", cnt_reads, 1);
        chk("t_hits", cnt_hits, 1);

        // Backpressure: 5 cycles of req_ready low
        bp_addr = 32'hCAFE_1F47;
        bus.req_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_op = 4'd1; bus.in_addr = bp_addr;
        tick();
        bus.in_valid = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", bus.req_valid, 1);
            chk("bp_addr", bus.req_addr, bp_addr);
            chk("bp_op", bus.req_op, 1);
            tick();
        end
        bus.req_ready = 1'b1;
        tick();
        chk("bp_valid_drop", bus.req_valid, 0);
        bus.rsp_valid = 1'b1; bus.rsp_hit = 1'b0;
        model_rsp(3'd1, 1'b0);
        tick();
        watch(4, nc, np, nb, nr);
        chk("bp_single_issue", nr, 0);
        chk_cnt("bp");

        // FIFO full: hold one request in ISSUE, then push 10
        svc(0, 1'b1, 4'd0, 32'hB000_0000, acc);
        svc(0, 1'b0, 4'd0, 32'd0, acc);
        n_acc = 0;
        for (int i = 0; i < 10; i++) begin
            svc(0, 1'b1, 4'(i % 3), 32'h1000_0000 + 32'(i) * 32'h0001_0044, acc);
            accv[i] = acc;
            n_acc += int'(acc);
        end
        chk("full_accepted", n_acc, 8);
        chk("full_reject9", accv[8], 0);
        chk("full_reject10", accv[9], 0);
        chk("full_in_ready", bus.in_ready, 0);
        drain(200);
        chk_cnt("full");

        // Clear, then counter mix
        svc(1, 1'b1, 4'd8, 32'd0, acc);
        watch(5, nc, np, nb, nr);
        chk("mix_clear_pulse", nc, 1);
        model_clear();
        chk_cnt("mix_cleared");
        hitq = '{1'b0, 1'b1, 1'b1, 1'b0};
        svc(1, 1'b1, 4'd1, 32'h0000_1000, acc);
        svc(1, 1'b1, 4'd2, 32'h0000_2040, acc);
        svc(1, 1'b1, 4'd3, 32'h0000_3080, acc);
        svc(1, 1'b1, 4'd5, 32'h0000_40C0, acc);
        drain(100);
        chk("mix_reads", cnt_reads, 1);
        chk("mix_writes", cnt_writes, 1);
        chk("mix_hits", cnt_hits, 1);
        chk("mix_misses", cnt_misses, 1);

        // Control ops with reads = 3
        svc(1, 1'b1, 4'd0, 32'h0001_0000, acc);
        svc(1, 1'b1, 4'd2, 32'h0002_0000, acc);
        drain(100);
        chk("ctl_reads3", cnt_reads, 3);
        svc(1, 1'b1, 4'd9, 32'd0, acc);
        watch(5, nc, np, nb, nr);
        chk("ctl_print_pulse", np, 1);
        chk("ctl_print_noclear", nc, 0);
        chk_cnt("ctl_print");
        svc(1, 1'b1, 4'd8, 32'd0, acc);
        watch(5, nc, np, nb, nr);
        chk("ctl_clear_pulse", nc, 1);
        model_clear();
        chk("ctl_clear_reads", cnt_reads, 0);
        chk_cnt("ctl_clear");
        svc(1, 1'b1, 4'd7, 32'hDEAD_BEEF, acc);
        watch(5, nc, np, nb, nr);
        chk("ctl_bad7", nb, 1);
        chk("ctl_bad7_noreq", nr, 0);
        svc(1, 1'b1, 4'd12, 32'h0BAD_0000, acc);
        watch(5, nc, np, nb, nr);
        chk("ctl_bad12", nb, 1);
        chk("ctl_bad12_noreq", nr, 0);

        // Reset while in WAIT_RSP with 3 entries queued
        svc(1, 1'b1, 4'd1, 32'h0005_0000, acc);
        drain(100);
        for (int i = 0; i < 4; i++)
            svc(0, 1'b1, 4'(i), 32'h0006_0000 + 32'(i), acc);
        svc(1, 1'b0, 4'd0, 32'd0, acc);
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_clear();
        expq.delete();
        outstanding = 1'b0;
        chk("mid_busy", busy, 0);
        chk("mid_in_ready", bus.in_ready, 1);
        chk_cnt("mid");
        watch(6, nc, np, nb, nr);
        chk("mid_no_req", nr, 0);

        // Randomized traffic
        for (int i = 0; i < 300; i++)
            svc(2, $urandom_range(0, 2) == 0, 4'($urandom_range(0, 6)), $urandom, acc);
        drain(400);
        chk_cnt("rand");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
